// File: rtl/wrr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wrr_arbiter_pkg                                                 |
// | Purpose  : Shared types and constants for the weighted round-robin arbiter.|
// |            Holds the arbitration state enum and the starvation limit used  |
// |            when WRR_ARBITER_STARVE_EN is defined.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package wrr_arbiter_pkg;

  // Arbitration state: ARB picks a fresh winner, HOLD keeps an offered
  // decision stable until the downstream side accepts it.
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Per-requester wait counter width and the value at which a requester
  // is considered starved.
  localparam int unsigned           StarveWidth = 8;
  localparam logic [StarveWidth-1:0] StarveLimit = 8'd255;

endpackage : wrr_arbiter_pkg
`default_nettype wire

// File: rtl/wrr_arbiter_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lzc                                                             |
// | Purpose  : Leading/trailing zero counter. With MODE=0 cnt_o is the index   |
// |            of the lowest set bit; with MODE=1 it is the number of zeros    |
// |            above the highest set bit. empty_o flags an all-zero input.     |
// | Ports    : in_i    [WIDTH]      input vector                               |
// |            cnt_o   [CNT_WIDTH]  zero count (0 when in_i is all zero)       |
// |            empty_o              in_i has no bit set                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o = '0;
    if (!MODE) begin
      // Scan downward so the lowest set bit is the last one to assign.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      // Scan upward so the highest set bit is the last one to assign.
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule : lzc
`default_nettype wire

// File: rtl/wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wrr_arbiter                                                     |
// | Purpose  : Weighted round-robin arbiter with a valid/ready style           |
// |            downstream port. Each requester may take weight+1 consecutive   |
// |            grants per turn. With LockIn set, an offered but not yet        |
// |            accepted decision is held stable until gnt_i.                   |
// | Ports    : clk_i, rst_i          clock, synchronous active-high reset      |
// |            flush_i               clear arbitration state                   |
// |            req_i   [NumIn]       upstream requests                         |
// |            gnt_o   [NumIn]       one-hot grant back to requesters          |
// |            data_i  [NumIn*DW]    payloads, requester i at [i*DW +: DW]     |
// |            weight_i[NumIn*WW]    grants per turn minus one                 |
// |            req_o, gnt_i          downstream valid / ready                  |
// |            data_o  [DW]          payload of the winner                     |
// |            idx_o   [log2 NumIn]  index of the winner                       |
// | Options  : define WRR_ARBITER_STARVE_EN to add 8-bit per-requester wait    |
// |            counters that force a starved requester to win.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter bit          LockIn      = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NumIn-1:0]             req_i,
  output logic [NumIn-1:0]             gnt_o,
  input  logic [NumIn*DataWidth-1:0]   data_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  output logic                         req_o,
  input  logic                         gnt_i,
  output logic [DataWidth-1:0]         data_o,
  output logic [$clog2(NumIn)-1:0]     idx_o
);

  localparam int unsigned IdxW = $clog2(NumIn);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [IdxW-1:0]        hold_idx_q, hold_idx_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [WeightWidth-1:0] cred_q, cred_d;

  logic [NumIn-1:0]       req_rot;
  logic [IdxW-1:0]        lzc_cnt;
  logic                   lzc_empty;
  logic [IdxW-1:0]        arb_idx;
  logic [IdxW-1:0]        winner;
  logic [IdxW-1:0]        winner_nxt;
  logic [WeightWidth-1:0] winner_weight;
  logic                   handshake;

  // --------------------------------------------------------------------------
  // Round-robin search: rotate requests so ptr lands on bit 0, find the
  // lowest set bit, then rotate the result back.
  // --------------------------------------------------------------------------
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < NumIn; i++) begin
      int j;
      j = i + int'(ptr_q);
      if (j >= int'(NumIn)) j = j - int'(NumIn);
      req_rot[i] = req_i[j];
    end
  end

  lzc #(
    .WIDTH     (NumIn),
    .MODE      (1'b0),
    .CNT_WIDTH (IdxW)
  ) u_lzc (
    .in_i    (req_rot),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  always_comb begin
    logic [IdxW:0] sum;
    sum = {1'b0, ptr_q} + {1'b0, lzc_cnt};
    if (sum >= (IdxW+1)'(NumIn)) sum = sum - (IdxW+1)'(NumIn);
    arb_idx = sum[IdxW-1:0];
  end

`ifdef WRR_ARBITER_STARVE_EN
  // --------------------------------------------------------------------------
  // Starvation guard: a requester whose wait counter has saturated overrides
  // the round-robin choice (lowest such index first) while arbitrating.
  // --------------------------------------------------------------------------
  logic [StarveWidth-1:0] wait_q [NumIn];
  logic [StarveWidth-1:0] wait_d [NumIn];
  logic                   starve_hit;
  logic [IdxW-1:0]        starve_idx;

  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (req_i[i] && (wait_q[i] == StarveLimit)) begin
        starve_hit = 1'b1;
        starve_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      wait_d[i] = wait_q[i];
      if (flush_i || gnt_o[i]) begin
        wait_d[i] = '0;
      end else if (req_i[i] && (wait_q[i] != StarveLimit)) begin
        wait_d[i] = wait_q[i] + StarveWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumIn; i++) begin
      if (rst_i) wait_q[i] <= '0;
      else       wait_q[i] <= wait_d[i];
    end
  end
`endif

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      hold_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_idx_q <= hold_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hold_idx_d = hold_idx_q;
    if (LockIn) begin
      case (state_q)
        ARB: begin
          // Offered but not taken: freeze this decision.
          if (req_o && !gnt_i) begin
            state_d    = HOLD;
            hold_idx_d = winner;
          end
        end
        HOLD: begin
          if (handshake) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
    if (flush_i) begin
      state_d    = ARB;
      hold_idx_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 3: outputs (winner select, payload mux, grant decode)
  // --------------------------------------------------------------------------
  always_comb begin
    winner = arb_idx;
    if (state_q == HOLD) begin
      winner = hold_idx_q;
    end
`ifdef WRR_ARBITER_STARVE_EN
    else if (starve_hit) begin
      winner = starve_idx;
    end
`endif
  end

  assign req_o     = ~lzc_empty;
  assign handshake = req_o & gnt_i;
  assign idx_o     = winner;
  assign data_o    = data_i[int'(winner)*DataWidth +: DataWidth];

  always_comb begin
    gnt_o         = '0;
    gnt_o[winner] = handshake;
  end

  // --------------------------------------------------------------------------
  // Weighted credit tracking
  // --------------------------------------------------------------------------
  assign winner_weight = weight_i[int'(winner)*WeightWidth +: WeightWidth];
  assign winner_nxt    = (winner == IdxW'(NumIn - 1)) ? '0 : winner + IdxW'(1);

  always_comb begin
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    owner_d = owner_q;
    if (handshake) begin
      if (winner != owner_q) begin
        // New owner: this grant is the first of its turn.
        owner_d = winner;
        cred_d  = WeightWidth'(1);
        if (winner_weight == '0) ptr_d = winner_nxt;
      end else if (cred_q >= winner_weight) begin
        // Turn used up: move past the owner.
        ptr_d  = winner_nxt;
        cred_d = '0;
      end else begin
        cred_d = cred_q + WeightWidth'(1);
        ptr_d  = winner;
      end
    end
    if (flush_i) begin
      ptr_d   = '0;
      cred_d  = '0;
      owner_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      cred_q  <= '0;
      owner_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      owner_q <= owner_d;
    end
  end

`ifndef SYNTHESIS
  // A held decision is only meaningful while its requester keeps asking.
  a_hold_req_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q == HOLD && !flush_i) |-> req_i[hold_idx_q]
  );
`endif

endmodule : wrr_arbiter
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wrr_arbiter                                                  |
// | Purpose  : Scoreboard bench for wrr_arbiter (NumIn=4, DW=32, WW=4).        |
// |            Stimulus pushes the hand-computed winner for every cycle with a |
// |            request; a negedge monitor pops and compares idx/data/gnt.      |
// |            Define WRR_ARBITER_STARVE_EN to also run the starvation case.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wrr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned WW = 4;

  logic            clk;
  logic            rst_i;
  logic            flush_i;
  logic [N-1:0]    req_i;
  logic [N-1:0]    gnt_o;
  logic [N*DW-1:0] data_i;
  logic [N*WW-1:0] weight_i;
  logic            req_o;
  logic            gnt_i;
  logic [DW-1:0]   data_o;
  logic [1:0]      idx_o;

  typedef struct {
    logic [1:0]    idx;
    logic [DW-1:0] data;
    logic [N-1:0]  gnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b1;

  wrr_arbiter #(
    .NumIn       (N),
    .DataWidth   (DW),
    .WeightWidth (WW),
    .LockIn      (1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .data_i   (data_i),
    .weight_i (weight_i),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .data_o   (data_o),
    .idx_o    (idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pay(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the expected winner is queued when any request is up.
  task automatic drive(input logic [N-1:0] r, input logic g, input int e, input logic fl);
    exp_t x;
    req_i   = r;
    gnt_i   = g;
    flush_i = fl;
    if (r != '0) begin
      x.idx  = 2'(e);
      x.data = pay(e);
      x.gnt  = g ? (N'(1) << e) : '0;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    drive('0, 1'b0, 0, 1'b1);
  endtask

  // Monitor: compare whenever the DUT presents a valid output.
  always @(negedge clk) begin
    if (mon_en && req_o) begin
      exp_t x;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_req_o: got idx %0d with no expected entry", idx_o);
      end else begin
        x = exp_q.pop_front();
        if (idx_o !== x.idx || data_o !== x.data || gnt_o !== x.gnt) begin
          n_fail++;
          $display("FAIL sb_cmp @%0t: got idx=%0d data=%h gnt=%b expected idx=%0d data=%h gnt=%b",
                   $time, idx_o, data_o, gnt_o, x.idx, x.data, x.gnt);
        end
      end
    end
  end

  // Hard time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i    = 1'b1;
    flush_i  = 1'b0;
    req_i    = '0;
    gnt_i    = 1'b0;
    weight_i = '0;
    for (int i = 0; i < N; i++) data_i[i*DW +: DW] = pay(i);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Reset state: nothing requested, nothing granted.
    chk("reset_req_o", 32'(req_o), 32'd0);
    chk("reset_gnt_o", 32'(gnt_o), 32'd0);
    gnt_i = 1'b1;
    #1;
    chk("reset_gnt_o_gnt_i_hi", 32'(gnt_o), 32'd0);

    // Equal weights, everybody requesting: plain round robin.
    weight_i = '0;
    drive(4'b1111, 1'b1, 0, 1'b0);
    drive(4'b1111, 1'b1, 1, 1'b0);
    drive(4'b1111, 1'b1, 2, 1'b0);
    drive(4'b1111, 1'b1, 3, 1'b0);
    drive(4'b1111, 1'b1, 0, 1'b0);
    do_flush();

    // weight[1]=2: requester 1 takes three grants per turn.
    weight_i = 16'h0020;
    drive(4'b0011, 1'b1, 0, 1'b0);
    drive(4'b0011, 1'b1, 1, 1'b0);
    drive(4'b0011, 1'b1, 1, 1'b0);
    drive(4'b0011, 1'b1, 1, 1'b0);
    drive(4'b0011, 1'b1, 0, 1'b0);
    drive(4'b0011, 1'b1, 1, 1'b0);
    drive(4'b0011, 1'b1, 1, 1'b0);
    drive(4'b0011, 1'b1, 1, 1'b0);
    do_flush();

    // Lock-in: decision for 2 held while downstream stalls, even after 0 asks.
    weight_i = '0;
    drive(4'b0100, 1'b0, 2, 1'b0);
    drive(4'b0100, 1'b0, 2, 1'b0);
    drive(4'b0100, 1'b0, 2, 1'b0);
    drive(4'b0101, 1'b0, 2, 1'b0);
    drive(4'b0101, 1'b1, 2, 1'b0);
    drive(4'b0101, 1'b1, 0, 1'b0);
    do_flush();

    // Flush mid-burst (weight[2]=3) wins over the simultaneous handshake;
    // afterwards weight[0]=1 gives 0,0 only if the credit was cleared.
    weight_i = 16'h0301;
    drive(4'b0100, 1'b1, 2, 1'b0);
    drive(4'b0100, 1'b1, 2, 1'b0);
    drive(4'b0101, 1'b1, 2, 1'b1);
    drive(4'b0101, 1'b1, 0, 1'b0);
    drive(4'b0101, 1'b1, 0, 1'b0);
    drive(4'b0101, 1'b1, 2, 1'b0);
    do_flush();

    // Reset mid-burst: pointer returns to 0, no grant while gnt_i is low.
    weight_i = '0;
    drive(4'b1111, 1'b1, 0, 1'b0);
    drive(4'b1111, 1'b1, 1, 1'b0);
    rst_i = 1'b1;
    drive(4'b1111, 1'b1, 2, 1'b0);
    rst_i = 1'b0;
    drive(4'b1111, 1'b0, 0, 1'b0);
    drive(4'b1111, 1'b1, 0, 1'b0);
    drive(4'b1111, 1'b1, 1, 1'b0);
    do_flush();

`ifdef WRR_ARBITER_STARVE_EN
    // Heavy requester 0 must not lock out requester 3 beyond 256 cycles.
    begin
      int wait_cyc;
      bit seen;
      mon_en   = 1'b0;
      seen     = 1'b0;
      wait_cyc = 0;
      weight_i = 16'h000F;
      req_i    = 4'b1001;
      gnt_i    = 1'b1;
      while (!seen && wait_cyc < 300) begin
        @(negedge clk);
        if (idx_o == 2'd3 && gnt_o[3]) seen = 1'b1;
        else wait_cyc++;
      end
      chk("starve_granted", 32'(seen), 32'd1);
      chk("starve_latency_le_256", 32'(wait_cyc <= 256), 32'd1);
      @(posedge clk);
      #1;
      do_flush();
      mon_en = 1'b1;
    end
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wrr_arbiter
`default_nettype wire

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter NumIn, default 4, meaning number of requesters (2..64).
REQ-002 SHALL have parameter DataWidth, default 32, meaning payload width per requester.
REQ-003 SHALL have parameter WeightWidth, default 4, meaning width of each per-requester weight.
REQ-004 SHALL have parameter LockIn, default 1'b1, meaning hold an ungranted decision until gnt_i.
REQ-005 SHALL have ports clk_i in 1 (clock) and rst_i in 1 (reset; single clock, synchronous, active-high).
REQ-006 SHALL have port flush_i in 1, which clears arbitration state.
REQ-007 SHALL have ports req_i in NumIn (requests) and gnt_o out NumIn (one-hot grant back to the requesters).
REQ-008 SHALL have port data_i in NumIn*DataWidth (payloads, requester i at bits [i*DataWidth +: DataWidth]).
REQ-009 SHALL have port weight_i in NumIn*WeightWidth (grants per turn minus one; quasi-static).
REQ-010 SHALL have ports req_o out 1, gnt_i in 1, data_o out DataWidth and idx_o out $clog2(NumIn) (downstream valid/ready side).

Function
REQ-011 SHALL assert req_o = |req_i; the winner SHALL be the first requesting index at or after ptr, scanning upward and wrapping at NumIn-1 to 0.
REQ-012 SHALL drive idx_o to the winner and data_o to data_i of the winner, combinationally with zero latency; data_o and idx_o SHALL be don't-care while req_o=0.
REQ-013 SHALL assert gnt_o[idx_o] = gnt_i & req_o and hold all other gnt_o bits at 0; a handshake is req_o & gnt_i.
REQ-014 SHALL keep registers ptr (index), cred (WeightWidth bits), owner (index) and state in {ARB, HOLD}.
REQ-015 SHALL, on a handshake with winner w: if w != owner, set owner<=w, cred<=1, and if weight[w]==0 also set ptr<=(w+1) mod NumIn.
REQ-016 SHALL, on a handshake with w == owner: if cred >= weight[w], set ptr<=(w+1) mod NumIn and cred<=0; otherwise set cred<=cred+1 and ptr<=w.
REQ-017 SHALL, while owner drops its request, leave cred unchanged until a different winner handshakes (REQ-015 then resets it).
REQ-018 SHALL, in ARB with LockIn=1 and req_o & ~gnt_i, move to HOLD and latch the winner index.
REQ-019 SHALL, in HOLD, force the winner to the latched index regardless of other requests and return to ARB on the handshake.
REQ-020 SHALL never change state when LockIn=0; the winner then follows REQ-011 every cycle.
REQ-021 SHALL, when flush_i=1, load reset values in the same cycle, with flush_i taking priority over any simultaneous handshake.
REQ-022 SHALL treat a requester dropping req_i while in HOLD as a protocol violation (assertion); the RTL behaviour in that case is unspecified.
REQ-023 SHALL make weight_i changes take effect at the next comparison.

Reset
REQ-024 SHALL, on rst_i at the clock edge, set ptr=0, cred=0, owner=0 and state=ARB; gnt_o SHALL then follow REQ-013 (all zero when gnt_i=0).

Configuration
REQ-025 SHALL, with macro WRR_ARBITER_STARVE_EN defined, keep a per-requester wait counter (8 bits, saturating) that increments while the requester waits ungranted and clears on its grant or flush.
REQ-026 SHALL, with WRR_ARBITER_STARVE_EN defined and a counter at 255, make the lowest such index win in ARB regardless of ptr, with cred/ptr updated per REQ-015/016.
REQ-027 SHALL, without WRR_ARBITER_STARVE_EN, contain no wait counters and behave exactly as REQ-011..024.

Structure
REQ-028 SHALL place the state enum (ARB, HOLD) and the StarveLimit constant (255) in package wrr_arbiter_pkg.
REQ-029 SHALL use one sub-module, lzc (common_cells), on the request vector rotated by ptr to find the winner.

Verification
REQ-030 SHALL cover: NumIn=4, all weights 0, req_i=4'b1111, gnt_i=1 -> idx_o sequence 0,1,2,3,0.
REQ-031 SHALL cover: weight[1]=2, weight[others]=0, req_i=4'b0011, gnt_i=1 -> idx_o 0,1,1,1,0,1,1,1.
REQ-032 SHALL cover: LockIn=1, req_i=4'b0100, gnt_i=0 for 3 cycles, then req_i=4'b0101 -> idx_o stays 2 until gnt_i=1, then idx_o=0.
REQ-033 SHALL cover: flush_i during a weight-3 burst after 2 grants to input 2 -> next winner is index 0 and cred=0.
REQ-034 SHALL cover: STARVE_EN, weight[0]=15 with input 0 always requesting, input 3 requesting and gnt_i=1 -> input 3 granted no later than 256 cycles after first request.
REQ-035 SHALL cover: rst_i asserted mid-burst -> ptr=0 and state ARB on the next cycle; gnt_o=0 while gnt_i=0.
